// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, frame field sizes and default memory geometry.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  // Frame layout: little-endian length header, payload, one XOR checksum byte
  localparam int HDR_LEN        = 2;
  localparam int CHK_LEN        = 1;
  localparam int LEN_W          = 8 * HDR_LEN;

  localparam int DEFAULT_DEPTH  = 1024;
  localparam int DEFAULT_ADDR_W = 10;

  // Total number of stream beats making up a frame with n payload bytes
  function automatic int frame_beats(input int n);
    return HDR_LEN + n + CHK_LEN;
  endfunction

endpackage

// File: rtl/imem_frame_counter.sv
// Frame bookkeeping for the boot loader: latched length, write address,
// payload byte count and running XOR checksum. Everything holds unless
// 'advance' (an accepted payload beat) or 'clear' (a new load) is asserted.
module imem_frame_counter
  import imem_boot_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic              len_lo_load,
  input  logic              len_hi_load,
  input  logic [7:0]        byte_in,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count,
  output logic              len_over,
  output logic              len_zero,
  output logic              last_beat,
  output logic              chk_match
);

  localparam logic [LEN_W:0] DEPTH_EXT = (LEN_W+1)'(DEPTH);

  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len;
  logic [7:0]       acc;
  logic [LEN_W-1:0] hdr_len;
  logic [LEN_W:0]   count_inc;

  // Length as it stands while the high header byte is on the stream,
  // so the overflow/zero decision is made in the same cycle as the beat
  assign hdr_len   = {byte_in, len_lo};
  assign len_over  = {1'b0, hdr_len} > DEPTH_EXT;
  assign len_zero  = (hdr_len == '0);

  // The current beat is the last payload byte when count+1 reaches N
  assign count_inc = (LEN_W+1)'(count) + (LEN_W+1)'(1);
  assign last_beat = (count_inc == {1'b0, len});

  assign chk_match = (byte_in == acc);

  // Latch the two header bytes as they arrive
  always_ff @(posedge clk) begin
    if (len_lo_load) len_lo <= byte_in;
    if (len_hi_load) len    <= {byte_in, len_lo};
  end

  // Address, byte count and checksum advance together on each payload beat
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      count <= '0;
      acc   <= '0;
    end else if (clear) begin
      addr  <= '0;
      count <= '0;
      acc   <= '0;
    end else if (advance) begin
      addr  <= addr + ADDR_W'(1);
      count <= count + (ADDR_W+1)'(1);
      acc   <= acc ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Power-up boot loader: receives a length-prefixed, XOR-checksummed program
// image over a byte stream, writes it into instruction memory from address 0
// and keeps the CPU held until the image has been loaded and verified.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   bytes_loaded
);

  state_t state, state_next;

  logic              clear;
  logic              advance;
  logic              len_lo_load;
  logic              len_hi_load;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic              len_over;
  logic              len_zero;
  logic              last_beat;
  logic              chk_match;

  imem_frame_counter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .advance     (advance),
    .len_lo_load (len_lo_load),
    .len_hi_load (len_hi_load),
    .byte_in     (rx_data),
    .addr        (addr),
    .count       (count),
    .len_over    (len_over),
    .len_zero    (len_zero),
    .last_beat   (last_beat),
    .chk_match   (chk_match)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // CPU release lags DONE entry by one cycle; a restart from DONE
  // re-asserts the hold on the same edge that leaves DONE
  always_ff @(posedge clk) begin
    if (rst) cpu_hold <= 1'b1;
    else     cpu_hold <= !((state == ST_DONE) && !start);
  end

  // Next-state logic and per-beat strobes; the write port is driven
  // straight from the accepted beat with no added latency
  always_comb begin
    state_next  = state;
    rx_ready    = 1'b0;
    mem_we      = 1'b0;
    clear       = 1'b0;
    advance     = 1'b0;
    len_lo_load = 1'b0;
    len_hi_load = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          clear      = 1'b1;
          state_next = ST_HDR0;
        end
      end
      ST_HDR0: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_lo_load = 1'b1;
          state_next  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_hi_load = 1'b1;
          if (len_over)      state_next = ST_ERR;
          else if (len_zero) state_next = ST_CHECK;
          else               state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          mem_we  = 1'b1;
          advance = 1'b1;
          if (last_beat) state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (chk_match) state_next = ST_DONE;
          else           state_next = ST_ERR;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem_waddr    = addr;
  assign mem_wdata    = mem_we ? rx_data : '0;
  assign done         = (state == ST_DONE);
  assign error        = (state == ST_ERR);
  assign bytes_loaded = count;

endmodule
